// File: rtl/link_tx_scheduler_pkg.sv
// Shared definitions for the link transmit scheduler: state encoding,
// data width and default timing/retry limits.
package link_pkg;

  localparam int DATA_W          = 32;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_MAX_RETRY   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/link_tx_scheduler_if.sv
// Bundle of requester-side and sender-side signals of the scheduler.
// Handshake: a requester holds ch_req high (level) with stable ch_data
// until it sees its ch_done or ch_err pulse; the sender gets a one-cycle
// snd_start and answers with a one-cycle snd_done; snd_abort resets the
// sender when an attempt is given up. dbg_state exposes the FSM state.
interface link_tx_scheduler_if #(
  parameter int NUM_CH = 4
);
  import link_pkg::*;

  logic [NUM_CH-1:0]        ch_req;
  logic [DATA_W*NUM_CH-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_grant;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_err;
  logic                     snd_start;
  logic [DATA_W-1:0]        snd_data;
  logic                     snd_done;
  logic                     snd_abort;
  logic                     busy;
  logic [15:0]              retry_total;
  state_t                   dbg_state;

  // Scheduler side
  modport master (
    input  ch_req, ch_data, snd_done,
    output ch_grant, ch_done, ch_err, snd_start, snd_data, snd_abort,
           busy, retry_total, dbg_state
  );

  // Requesters/sender/environment side
  modport slave (
    output ch_req, ch_data, snd_done,
    input  ch_grant, ch_done, ch_err, snd_start, snd_data, snd_abort,
           busy, retry_total, dbg_state
  );

endinterface

// File: rtl/link_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around. Returns a one-hot grant, its index and a found flag.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     idx,
  output logic              any
);

  logic [IW-1:0] cand;

  // Scan channels in priority order starting from ptr
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_CH);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/link_tx_scheduler.sv
// Shares one transmit sender between NUM_CH requesters. Round-robin grant,
// start pulse, wait for done; a watchdog aborts and retries stalled
// attempts up to MAX_RETRY times before reporting an error.
module link_tx_scheduler
  import link_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input logic                clk,
  input logic                rst,
  link_tx_scheduler_if.master bus
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t            state, state_n;
  logic [NUM_CH-1:0] grant_r;
  logic [IW-1:0]     idx_r;
  logic [IW-1:0]     ptr;
  logic [TW-1:0]     timer;
  logic [RW-1:0]     retry_cnt;
  logic [15:0]       retry_total;
  logic [NUM_CH-1:0] done_r;
  logic [NUM_CH-1:0] err_r;

  logic [NUM_CH-1:0] arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;

  logic              timeout;
  logic              can_retry;
  logic [IW-1:0]     next_ptr;

  // FSM strobes
  logic              do_grant;
  logic              do_retry;
  logic              fin_done;
  logic              fin_err;

  rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
    .req   (bus.ch_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign timeout   = (timer == TW'(TIMEOUT_CYC - 1));
  assign can_retry = (retry_cnt < RW'(MAX_RETRY));
  assign next_ptr  = (idx_r == IW'(NUM_CH - 1)) ? '0 : idx_r + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state logic and datapath strobes; done has priority over timeout
  always_comb begin
    state_n  = state;
    do_grant = 1'b0;
    do_retry = 1'b0;
    fin_done = 1'b0;
    fin_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          do_grant = 1'b1;
          state_n  = ST_START;
        end
      end
      ST_START: state_n = ST_BUSY;
      ST_BUSY: begin
        if (bus.snd_done) begin
          fin_done = 1'b1;
          state_n  = ST_IDLE;
        end else if (timeout) begin
          if (can_retry) begin
            do_retry = 1'b1;
            state_n  = ST_RECOVER;
          end else begin
            fin_err = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      ST_RECOVER: state_n = ST_START;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Grant, pointer, timer, retry counters and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r     <= '0;
      idx_r       <= '0;
      ptr         <= '0;
      timer       <= '0;
      retry_cnt   <= '0;
      retry_total <= '0;
      done_r      <= '0;
      err_r       <= '0;
    end else begin
      done_r <= '0;
      err_r  <= '0;
      if (do_grant) begin
        grant_r   <= arb_grant;
        idx_r     <= arb_idx;
        retry_cnt <= '0;
      end
      if (state == ST_START)     timer <= '0;
      else if (state == ST_BUSY) timer <= timer + 1'b1;
      if (do_retry) begin
        retry_cnt <= retry_cnt + 1'b1;
        if (retry_total != 16'hFFFF) retry_total <= retry_total + 16'd1;
      end
      if (fin_done) begin
        done_r  <= grant_r;
        grant_r <= '0;
        ptr     <= next_ptr;
      end
      if (fin_err) begin
        err_r   <= grant_r;
        grant_r <= '0;
        ptr     <= next_ptr;
      end
    end
  end

  assign bus.ch_grant    = grant_r;
  assign bus.ch_done     = done_r;
  assign bus.ch_err      = err_r;
  assign bus.snd_start   = (state == ST_START);
  assign bus.snd_abort   = (state == ST_RECOVER);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.retry_total = retry_total;
  assign bus.dbg_state   = state;
  assign bus.snd_data    = (|grant_r) ? bus.ch_data[int'(idx_r)*DATA_W +: DATA_W]
                                      : '0;

endmodule
